// File: rtl/divu_sequencer.sv
// Multi-cycle unsigned divider feeding LO/HI, with pipeline stall generation for DIVU/MFLO.
// Optional feature macro: DIVU_EARLY_OUT_EN (skip the iteration when divisor > dividend).
module divu_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mflo_req,
    output logic             stall,
    output logic             busy,
    output logic             lo_we,
    output logic [WIDTH-1:0] lo_data,
    output logic [WIDTH-1:0] hi_data,
    output logic             div_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic             lo_we_q;

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // One restoring step; the extra top bit of trial is the borrow.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {2'b00, dsr};
        rem_next = shifted[WIDTH:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            rem_next = trial[WIDTH:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            busy     <= 1'b0;
            lo_we_q  <= 1'b0;
            lo_data  <= '0;
            hi_data  <= '0;
            div_zero <= 1'b0;
        end else begin
            lo_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        dsr   <= divisor;
                        quo   <= dividend;
                        rem   <= '0;
                        count <= CW'(WIDTH);
                        busy  <= 1'b1;
                        if (divisor == '0) begin
                            state    <= DONE;
                            lo_we_q  <= 1'b1;
                            lo_data  <= '1;
                            hi_data  <= dividend;
                            div_zero <= 1'b1;
                        end
`ifdef DIVU_EARLY_OUT_EN
                        else if (divisor > dividend) begin
                            state    <= DONE;
                            lo_we_q  <= 1'b1;
                            lo_data  <= '0;
                            hi_data  <= dividend;
                            div_zero <= 1'b0;
                        end
`endif
                        else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        count <= '0;
                    end else begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state    <= DONE;
                            lo_we_q  <= 1'b1;
                            lo_data  <= quo_next;
                            hi_data  <= rem_next[WIDTH-1:0];
                            div_zero <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A flush landing in DONE must cancel the LO write in the same cycle.
    assign lo_we = lo_we_q && !flush;

    assign stall = !flush && ((mflo_req && (busy || start)) || (start && busy));

endmodule

// File: tb/tb_divu_sequencer.sv
// Self-checking bench for divu_sequencer: directed and random divides against an arithmetic reference.
module tb_divu_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        mflo_req;
    logic        stall;
    logic        busy;
    logic        lo_we;
    logic [31:0] lo_data;
    logic [31:0] hi_data;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    divu_sequencer #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .flush    (flush),
        .dividend (dividend),
        .divisor  (divisor),
        .mflo_req (mflo_req),
        .stall    (stall),
        .busy     (busy),
        .lo_we    (lo_we),
        .lo_data  (lo_data),
        .hi_data  (hi_data),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge (start of the next cycle).
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
`ifdef DIVU_EARLY_OUT_EN
        if (b > a) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) ? a : a % b;
    endfunction

    // Issue one DIVU in cycle 0; optional MFLO held from cycle 1; optional flush in cycle flush_at.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit mflo, input int flush_at);
        int  lat;
        bit  killed;
        bit  busy_e;
        bit  we_e;
        lat    = exp_lat(a, b);
        killed = (flush_at > 0) && (flush_at <= lat);
        start = 1'b1; dividend = a; divisor = b; mflo_req = 1'b0; flush = 1'b0;
        #1;
        chk("stall_c0", 32'(stall), 32'(0));
        next();
        start = 1'b0; dividend = $urandom; divisor = $urandom; mflo_req = mflo;
        for (int c = 1; c <= lat + 1; c++) begin
            flush = (c == flush_at);
            #1;
            busy_e = (c <= lat) && !(killed && c > flush_at);
            we_e   = (c == lat) && !(killed && c >= flush_at);
            chk("busy", 32'(busy), 32'(busy_e));
            chk("lo_we", 32'(lo_we), 32'(we_e));
            chk("stall", 32'(stall), 32'(mflo && busy_e && (c != flush_at)));
            if (we_e) begin
                chk("lo_data", lo_data, ref_q(a, b));
                chk("hi_data", hi_data, ref_r(a, b));
                chk("div_zero", 32'(div_zero), 32'(b == 32'd0));
            end
            next();
        end
        flush = 1'b0; mflo_req = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; flush = 1'b0; mflo_req = 1'b0;
        dividend = '0; divisor = '0;
        next();
        next();
        rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_lo_we", 32'(lo_we), 32'(0));
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_lo_data", lo_data, 32'(0));
        chk("rst_hi_data", hi_data, 32'(0));
        chk("rst_div_zero", 32'(div_zero), 32'(0));
        next();

        // Directed cases.
        do_div(32'd100, 32'd7, 1'b0, -1);
        do_div(32'hFFFF_FFFF, 32'd0, 1'b0, -1);
        do_div(32'd50, 32'd5, 1'b1, -1);
        do_div(32'd3, 32'd9, 1'b0, -1);
        do_div(32'hFFFF_FFFF, 32'd1, 1'b0, -1);
        do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);

        // Flush mid-run with MFLO waiting, and flush landing on the DONE cycle.
        do_div(32'd123456, 32'd789, 1'b1, 10);
        do_div(32'd99999, 32'd10, 1'b0, 33);

        // start together with flush in IDLE is ignored.
        start = 1'b1; flush = 1'b1; dividend = 32'd8; divisor = 32'd2;
        #1;
        chk("flush_start_stall", 32'(stall), 32'(0));
        next();
        start = 1'b0; flush = 1'b0;
        #1;
        chk("flush_start_busy", 32'(busy), 32'(0));
        next();

        // Reset in the middle of a run.
        start = 1'b1; dividend = 32'd5000; divisor = 32'd7;
        next();
        start = 1'b0;
        for (int c = 1; c < 20; c++) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_lo_we", 32'(lo_we), 32'(0));
        chk("mid_rst_stall", 32'(stall), 32'(0));
        chk("mid_rst_lo_data", lo_data, 32'(0));
        chk("mid_rst_hi_data", hi_data, 32'(0));
        chk("mid_rst_div_zero", 32'(div_zero), 32'(0));
        for (int c = 0; c < 16; c++) begin
            next();
            chk("mid_rst_no_we", 32'(lo_we), 32'(0));
        end
        next();

        // Second DIVU held in EX while the first one runs.
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3;
        for (int c = 0; c <= 68; c++) begin
            bit busy_e;
            if (c == 1) begin dividend = 32'd77777; divisor = 32'd123; end
            if (c == 35) start = 1'b0;
            #1;
            busy_e = (c >= 1 && c <= 33) || (c >= 35 && c <= 67);
            chk("held_busy", 32'(busy), 32'(busy_e));
            chk("held_stall", 32'(stall), 32'((c <= 34) && busy_e));
            chk("held_lo_we", 32'(lo_we), 32'(c == 33 || c == 67));
            if (c == 33) chk("held_lo1", lo_data, 32'd333);
            if (c == 67) begin
                chk("held_lo2", lo_data, 32'd77777 / 32'd123);
                chk("held_hi2", hi_data, 32'd77777 % 32'd123);
            end
            next();
        end

        // Random divides.
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = 32'($urandom_range(0, 15));
                2: rb = ra >> $urandom_range(0, 31);
                default: rb = 32'($urandom_range(1, 65535));
            endcase
            do_div(ra, rb, bit'($urandom_range(0, 1)), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divu_sequencer.md
# divu_sequencer

Multi-cycle sequencer for the unsigned-divide resource behind DIVU/MFLO. It accepts a DIVU issued from EX, runs a one-bit-per-cycle restoring division, and writes the quotient into LO through a single-cycle write strobe. While the result is pending it stalls the pipeline whenever an MFLO or a second DIVU would need it. It sits beside the ALU in EX, takes WE_LO as its start, and drives the LO register write port and the global stall line.

## Interface
Parameters:
- WIDTH, 32, operand and quotient width in bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  DIVU in EX (the WE_LO decode); sampled each edge.
- flush  in  1  branch-mispredict flush; kills the in-flight divide.
- dividend  in  WIDTH  rs value, sampled on the accepting edge.
- divisor  in  WIDTH  rt value, sampled on the accepting edge.
- mflo_req  in  1  MFLO present in EX.
- stall  out  1  freezes PC/IF/ID/EX; combinational.
- busy  out  1  high in RUN and DONE.
- lo_we  out  1  one-cycle LO write strobe.
- lo_data  out  WIDTH  quotient; valid while lo_we is high.
- hi_data  out  WIDTH  remainder; valid while lo_we is high, held afterwards.
- div_zero  out  1  divisor was 0 for the result being written; qualified by lo_we.

## Operation
States:
- IDLE: default state.
  - start && !flush: latch operands, clear the remainder, set count=WIDTH. Next state is RUN, or DONE for the divide-by-zero fast path.
- RUN: each edge shifts {rem,quo} left by 1. Trial = rem − divisor.
  - If the trial does not underflow: rem = trial, quotient LSB = 1.
  - Otherwise: quotient LSB = 0.
  - count decrements; when it reaches 0 the next state is DONE.
- DONE: lo_we=1 for exactly this cycle; next state is IDLE.

Rules:
- Divide-by-zero: quotient = all ones, remainder = dividend, div_zero=1. Goes IDLE→DONE directly.
- Arithmetic: remainder register is WIDTH+1 bits so the borrow is visible. Everything is unsigned. No overflow is possible.
- start while busy: ignored, and stall=1. EX holds the DIVU, so start stays high. It is accepted on the edge after DONE, i.e. while the state is IDLE.
- stall = (mflo_req && (busy || start)) || (start && busy).
  - stall is forced to 0 while flush=1.
- flush:
  - In RUN or DONE: next state IDLE, lo_we suppressed.
  - In DONE: lo_we is forced to 0 combinationally.
  - flush with start in IDLE: start is ignored.
- rst: state IDLE, count 0, all outputs 0. Mid-run reset discards the operation with no LO write.
- Outputs are registered except stall and the lo_we flush gating.

## Timing
- Start accepted at edge E0. RUN covers edges E1..E_WIDTH. DONE is the cycle after E_WIDTH, and LO is written at E_WIDTH+1.
  - For WIDTH=32: start in cycle 0 gives lo_we in cycle 33.
- Divide-by-zero: lo_we in cycle 1.
- An MFLO following DIVU stalls from its EX entry until the cycle after lo_we. In that cycle LO is updated, so the forwarding path is not needed.
- busy drops in the cycle after DONE. A new start can be accepted in that same cycle.
- Reset values:
  - stall=0, busy=0, lo_we=0, div_zero=0.
  - lo_data=0, hi_data=0.

## Configuration
- DIVU_EARLY_OUT_EN defined: in IDLE, when divisor > dividend (divisor ≠ 0), the block goes directly to DONE. Result is quotient 0, remainder = dividend, and lo_we comes in cycle 1.
- DIVU_EARLY_OUT_EN undefined: every nonzero-divisor divide takes the full WIDTH+1 cycles. The divide-by-zero fast path exists in both builds.

## Test plan
- dividend=100, divisor=7, start in cycle 0 → lo_we only in cycle 33, lo_data=14, hi_data=2, div_zero=0. busy is high for cycles 1–33.
- dividend=0xFFFFFFFF, divisor=0 → lo_we in cycle 1, lo_data=0xFFFFFFFF, hi_data=0xFFFFFFFF, div_zero=1.
- DIVU (50/5), then MFLO held in EX from cycle 1 → stall=1 for cycles 1–33, stall=0 in cycle 34, LO=10.
- flush at cycle 10 of a run → busy=0 from cycle 11, no lo_we pulse, LO unchanged. Also reset asserted at cycle 20 of a separate run → all outputs 0 the next cycle.
- Second start held while busy → stall=1 until DONE. The second divide is accepted in cycle 34 and its lo_we comes in cycle 67.
- With DIVU_EARLY_OUT_EN, 3/9 → lo_we in cycle 1, lo_data=0, hi_data=3. Without the macro, the same divide gives lo_we in cycle 33.
